multi_sense_filt: RTL and testbench
===================================

# multi_sense_filt

Parametrised N-channel successor to the single-channel cadence filter. Each channel synchronises a raw asynchronous, bouncy sensor input and debounces it with a saturating stability counter. Each channel also produces rise and fall pulses on the filtered level, and measures the rise-to-rise period with stall detection. It sits between the pedal/brake/aux sensor pins and the sensor-conditioning and cadence-rate logic.

## Interface
Parameters:
- NUM_CH, default 4: number of independent channels (≥1).
- FAST_SIM, default 1: 1 gives an 8-bit stability window; 0 gives a STBL_W-bit window.
- STBL_W, default 16: stability counter width when FAST_SIM=0 (≥8).
- PER_W, default 24: period counter width (≥4).

Ports:
- clk, input, 1: 50 MHz system clock. This is the only clock.
- rst_n, input, 1: asynchronous active-low reset.
- raw_in, input, NUM_CH: raw asynchronous sensor inputs.
- filt, output, NUM_CH: debounced, metastability-free levels.
- rise, output, NUM_CH: one-cycle pulse when filt[i] goes 0→1.
- fall, output, NUM_CH: one-cycle pulse when filt[i] goes 1→0.
- per_q, output, NUM_CH*PER_W: last measured rise-to-rise period per channel. Channel i occupies [i*PER_W +: PER_W].
- per_vld, output, NUM_CH: one-cycle pulse when per_q[i] is updated.
- stall, output, NUM_CH: high while channel i's period counter is saturated.

## Operation
Reset values: all flops are 0. filt, rise, fall, per_q, per_vld and stall are all 0. The period counter is 0 and each channel starts disarmed.

Channels are fully independent. They share no state.

Per-channel pipeline:
- Synchronisation: sync1 ← raw_in[i], then sync2 ← sync1, then prev ← sync2.
- Change detect: chg = sync2 ^ prev.
- Stability counter (cnt):
  - STBL_MAX = 2^8−1 if FAST_SIM=1, otherwise 2^STBL_W−1.
  - If chg, cnt ← 0.
  - Else if cnt ≠ STBL_MAX, cnt ← cnt+1.
  - Otherwise cnt holds at STBL_MAX. It saturates and never wraps.
- Filter: when cnt == STBL_MAX, filt ← prev. Otherwise filt holds.
- Edges: rise and fall are registered and derived from the filtered level (filt_next vs filt). They are never derived from the raw or synchronised signal. rise and fall are mutually exclusive.

Per-channel period measurement:
- Period counter (pcnt) increments every cycle and saturates at 2^PER_W−1.
- On rise:
  - If the channel is armed and stall=0: per_q ← pcnt+1 and per_vld pulses.
  - In all cases: pcnt ← 0 and the channel becomes armed.
- The first rise after reset only arms the channel. It produces no per_vld.
- stall = (pcnt == 2^PER_W−1) && armed. stall is registered.
  - A rise while stalled produces no per_vld. It clears stall the following cycle and restarts measurement.
- per_q holds its value between updates, including while stalled.

## Timing
- Count edge 1 as the first clk edge at which sync1 captures the new raw level. filt changes at edge STBL_MAX+4, which is edge 259 for FAST_SIM=1. rise/fall assert in the same cycle filt changes.
- Glitch rejection: a sync2 excursion shorter than STBL_MAX+1 cycles never reaches filt.
- per_vld and the per_q update occur in the same cycle as the rise that ends the period.
- A rise exactly when pcnt saturates is treated as stalled: no per_vld.
- Asserting rst_n low mid-count clears all state asynchronously. After reset the channel must see STBL_MAX+4 stable cycles before filt changes again.

## Structure
- Package multi_sense_filt_pkg holds:
  - localparam function stbl_max(FAST_SIM, STBL_W).
  - The per-channel typedef of {filt, rise, fall, per_vld, stall} status.
- Sub-module sense_filt_ch implements one complete channel (sync, debounce, edges, period).
- The top level is a generate loop over NUM_CH plus per_q packing.

## Test plan
- Reset, FAST_SIM=1: drive raw_in[0] 0→1 and hold. filt[0] rises at edge 259; rise[0] is high for exactly 1 cycle. No other channel moves.
- Bounce: toggle raw_in[1] every 100 cycles for 2000 cycles, then hold at 1. filt[1] stays 0 during bouncing and goes to 1 at 259 cycles after the last toggle is sampled.
- Falling edge: with filt[2]=1, drive raw_in[2] to 0 and hold. fall[2] pulses once at edge 259; rise[2] stays 0.
- Period, PER_W=24: produce clean filtered rises 5000 cycles apart on ch 3. The first rise gives no per_vld. The second gives per_vld=1 with per_q[3]=5000, and the third does the same.
- Stall, PER_W=8: filtered rises 1000 cycles apart. stall asserts 255 cycles after an armed rise. The next rise gives no per_vld and stall clears; the following rise also gives no per_vld because the period again exceeds 255.
- Reset mid-count: pulse rst_n low while cnt≈200 on ch 0. All outputs go to 0 immediately, and filt needs a full 259-cycle window after reset release.

Source files
------------

// File: rtl/multi_sense_filt_pkg.sv
`default_nettype none
// multi_sense_filt_pkg: stability-window sizing helpers and the per-channel status record.
// Rev 1.0
package multi_sense_filt_pkg;

  function automatic int cnt_width(int fast_sim, int stbl_w);
    return (fast_sim != 0) ? 8 : stbl_w;
  endfunction

  function automatic logic [63:0] stbl_max(int fast_sim, int stbl_w);
    return (64'd1 << cnt_width(fast_sim, stbl_w)) - 64'd1;
  endfunction

  typedef struct packed {
    logic filt;
    logic rise;
    logic fall;
    logic per_vld;
    logic stall;
  } ch_status_t;

endpackage
`default_nettype wire

// File: rtl/sense_filt_ch.sv
`default_nettype none
// sense_filt_ch: one sensor channel - 2-flop sync, saturating debounce, edge pulses,
// and rise-to-rise period measurement with stall detection. Rev 1.0
module sense_filt_ch
  import multi_sense_filt_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int STBL_W   = 16,
  parameter int PER_W    = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_i,
  output ch_status_t       status_o,
  output logic [PER_W-1:0] per_o
);

  localparam int                CNT_W    = cnt_width(FAST_SIM, STBL_W);
  localparam logic [CNT_W-1:0]  STBL_MAX = CNT_W'(stbl_max(FAST_SIM, STBL_W));
  localparam logic [PER_W-1:0]  PER_MAX  = '1;

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [PER_W-1:0] pcnt_q, pcnt_d;
  logic             armed_q, armed_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             stall_q, stall_d;
  logic             chg;

  always_comb begin
    chg      = sync2_q ^ prev_q;
    cnt_d    = cnt_q;
    if (chg) begin
      cnt_d = '0;
    end else if (cnt_q != STBL_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    filt_d   = (cnt_q == STBL_MAX) ? prev_q : filt_q;
    rise_d   = filt_d & ~filt_q;
    fall_d   = ~filt_d & filt_q;

    pcnt_d   = (pcnt_q != PER_MAX) ? pcnt_q + 1'b1 : pcnt_q;
    armed_d  = armed_q;
    period_d = period_q;
    vld_d    = 1'b0;
    // A rise while stalled (pcnt saturated) only restarts the measurement.
    if (rise_d) begin
      if (armed_q && !stall_q) begin
        period_d = pcnt_q + 1'b1;
        vld_d    = 1'b1;
      end
      pcnt_d  = '0;
      armed_d = 1'b1;
    end
    stall_d  = armed_d && (pcnt_d == PER_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pcnt_q   <= '0;
      armed_q  <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pcnt_q   <= pcnt_d;
      armed_q  <= armed_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      stall_q  <= stall_d;
    end
  end

  assign status_o = '{filt: filt_q, rise: rise_q, fall: fall_q, per_vld: vld_q, stall: stall_q};
  assign per_o    = period_q;

endmodule
`default_nettype wire

// File: rtl/multi_sense_filt.sv
`default_nettype none
// multi_sense_filt: NUM_CH independent debounce/edge/period channels with packed period outputs.
// Rev 1.0
module multi_sense_filt
  import multi_sense_filt_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int FAST_SIM = 1,
  parameter int STBL_W   = 16,
  parameter int PER_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       raw_in,
  output logic [NUM_CH-1:0]       filt,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH-1:0]       fall,
  output logic [NUM_CH*PER_W-1:0] per_q,
  output logic [NUM_CH-1:0]       per_vld,
  output logic [NUM_CH-1:0]       stall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_status_t       st;
    logic [PER_W-1:0] per;

    sense_filt_ch #(
      .FAST_SIM (FAST_SIM),
      .STBL_W   (STBL_W),
      .PER_W    (PER_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (raw_in[i]),
      .status_o (st),
      .per_o    (per)
    );

    assign filt[i]                  = st.filt;
    assign rise[i]                  = st.rise;
    assign fall[i]                  = st.fall;
    assign per_vld[i]               = st.per_vld;
    assign stall[i]                 = st.stall;
    assign per_q[i*PER_W +: PER_W]  = per;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_sense_filt.sv
`default_nettype none
// tb_multi_sense_filt: directed + random stimulus against a window-based reference model.
// Rev 1.0
module tb_multi_sense_filt;

  localparam int NCH = 4;
  localparam int PW  = 24;
  localparam int PWS = 8;
  localparam int NM  = 5;   // model channels: 0..3 main DUT, 4 = PER_W=8 DUT
  localparam int SMX = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0]    raw_in = '0;
  logic [NCH-1:0]    filt, rise, fall, per_vld, stall;
  logic [NCH*PW-1:0] per_q;
  logic [0:0]        raw_s = '0;
  logic [0:0]        filt_s, rise_s, fall_s, vld_s, stall_s;
  logic [PWS-1:0]    per_s;

  always #10 clk = ~clk;

  multi_sense_filt #(.NUM_CH(NCH), .FAST_SIM(1), .STBL_W(16), .PER_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .filt(filt), .rise(rise), .fall(fall),
    .per_q(per_q), .per_vld(per_vld), .stall(stall));

  multi_sense_filt #(.NUM_CH(1), .FAST_SIM(1), .STBL_W(16), .PER_W(PWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_s), .filt(filt_s), .rise(rise_s), .fall(fall_s),
    .per_q(per_s), .per_vld(vld_s), .stall(stall_s));

  // Reference model: raw history per channel, filt follows a fully stable window.
  bit hist[NM][$];
  bit mf[NM], mr[NM], mfl[NM], mv[NM], ms[NM], marm[NM];
  int mper[NM], mlast[NM], pmax[NM];
  int k;
  int npass = 0, ntotal = 0, nfail = 0;
  int rise0_k, rise0_n, vld3_n, vld_s_n, stall_s_n;

  function automatic bit r_at(int c, int j);
    if (j < 1) return 1'b0;
    return hist[c][j-1];
  endfunction

  // filt takes r[k-3] only if the SMX+1 samples r[k-3-SMX .. k-3] all agree.
  function automatic bit window_const(int c);
    bit v = r_at(c, k - 3);
    for (int j = k - 3 - SMX; j < k - 3; j++)
      if (r_at(c, j) != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < NM; c++) begin
      hist[c].delete();
      mf[c] = 0; mr[c] = 0; mfl[c] = 0; mv[c] = 0; ms[c] = 0; marm[c] = 0;
      mper[c] = 0; mlast[c] = 0;
      pmax[c] = (c < NCH) ? (1 << PW) - 1 : (1 << PWS) - 1;
    end
    rise0_k = -1; rise0_n = 0;
  endtask

  task automatic model_edge(input logic [NM-1:0] v);
    bit pf;
    k++;
    for (int c = 0; c < NM; c++) begin
      hist[c].push_back(v[c]);
      pf = mf[c];
      if (window_const(c)) mf[c] = r_at(c, k - 3);
      mr[c]  = mf[c] & ~pf;
      mfl[c] = ~mf[c] & pf;
      mv[c]  = 0;
      if (mr[c]) begin
        if (marm[c] && (k - mlast[c]) <= pmax[c]) begin
          mv[c]   = 1;
          mper[c] = k - mlast[c];
        end
        marm[c]  = 1;
        mlast[c] = k;
      end
      ms[c] = marm[c] && ((k - mlast[c]) >= pmax[c]);
    end
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s ch%0d: observed 0x%0h required 0x%0h (edge %0d)", tag, c, obs, exp, k);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      chk("filt",    c, 32'(filt[c]),    32'(mf[c]));
      chk("rise",    c, 32'(rise[c]),    32'(mr[c]));
      chk("fall",    c, 32'(fall[c]),    32'(mfl[c]));
      chk("per_vld", c, 32'(per_vld[c]), 32'(mv[c]));
      chk("stall",   c, 32'(stall[c]),   32'(ms[c]));
      chk("per_q",   c, 32'(per_q[c*PW +: PW]), mper[c]);
    end
    chk("filt",    4, 32'(filt_s), 32'(mf[4]));
    chk("rise",    4, 32'(rise_s), 32'(mr[4]));
    chk("fall",    4, 32'(fall_s), 32'(mfl[4]));
    chk("per_vld", 4, 32'(vld_s),  32'(mv[4]));
    chk("stall",   4, 32'(stall_s), 32'(ms[4]));
    chk("per_q",   4, 32'(per_s),  mper[4]);
    if (rise[0] === 1'b1) begin
      rise0_n++;
      if (rise0_k < 0) rise0_k = k;
    end
    if (per_vld[3] === 1'b1) vld3_n++;
    if (vld_s === 1'b1) vld_s_n++;
    if (stall_s === 1'b1) stall_s_n++;
  endtask

  task automatic step(input logic [NM-1:0] v);
    raw_in = v[NCH-1:0];
    raw_s  = v[NM-1:NCH];
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check_all();
  endtask

  task automatic tick(input logic [NM-1:0] v, input int n);
    repeat (n) step(v);
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    #2;
    chk("rst_filt",  0, 32'(filt),    0);
    chk("rst_rise",  0, 32'(rise),    0);
    chk("rst_fall",  0, 32'(fall),    0);
    chk("rst_vld",   0, 32'(per_vld), 0);
    chk("rst_stall", 0, 32'(stall),   0);
    chk("rst_per0",  0, 32'(per_q[31:0]), 0);
    chk("rst_per3",  3, 32'(per_q[3*PW +: PW]), 0);
    chk("rst_filt",  4, 32'(filt_s),  0);
    chk("rst_per",   4, 32'(per_s),   0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [NM-1:0] rv;
  int cd[NM];

  initial begin
    rv = '0;
    @(posedge clk);
    @(negedge clk);
    reset_and_check();

    // Clean rising edge on channel 0.
    rv[0] = 1'b1;
    tick(rv, 300);
    chk("rise0_edge", 0, 32'(rise0_k), 259);
    chk("rise0_cnt",  0, 32'(rise0_n), 1);

    // Bouncing channel 1, then a steady high.
    for (int t = 0; t < 20; t++) begin
      rv[1] = ~rv[1];
      tick(rv, 100);
    end
    chk("bounce_filt", 1, 32'(filt[1]), 0);
    rv[1] = 1'b1;
    tick(rv, 300);

    // Rise then fall on channel 2.
    rv[2] = 1'b1;
    tick(rv, 300);
    rv[2] = 1'b0;
    tick(rv, 300);

    // Periods: 5000 on channel 3, 1000 on the 8-bit period DUT.
    vld3_n = 0; vld_s_n = 0; stall_s_n = 0;
    for (int t = 0; t < 20000; t++) begin
      rv[3] = ((t % 5000) < 300);
      rv[4] = ((t % 1000) < 300);
      step(rv);
    end
    chk("vld3_cnt",   3, 32'(vld3_n), 3);
    chk("per3_value", 3, 32'(per_q[3*PW +: PW]), 5000);
    chk("vld_s_cnt",  4, 32'(vld_s_n), 0);
    chk("stall_seen", 4, 32'(stall_s_n > 0), 1);

    // Random bounce/hold mix on every channel.
    for (int c = 0; c < NM; c++) cd[c] = 0;
    repeat (20000) begin
      for (int c = 0; c < NM; c++) begin
        if (cd[c] == 0) begin
          rv[c] = ~rv[c];
          cd[c] = ($urandom_range(1, 0) == 1) ? int'($urandom_range(40, 1))
                                              : int'($urandom_range(700, 260));
        end else begin
          cd[c]--;
        end
      end
      step(rv);
    end

    // Reset in the middle of a debounce window on channel 0.
    rv = '0;
    tick(rv, 300);
    rv[0] = 1'b1;
    tick(rv, 200);
    @(negedge clk);
    reset_and_check();
    tick(rv, 300);
    chk("rst_rise0_edge", 0, 32'(rise0_k), 259);
    chk("rst_rise0_cnt",  0, 32'(rise0_n), 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire
